// File: rtl/ch_gain_cal_mul_arb.sv
// ch_gain_cal_mul_arb
// Shares one 3-stage signed x unsigned multiplier (16s x 17u -> 34s) between
// NUM_REQ requesters. A round-robin arbiter issues at most one operand pair per
// cycle. A {valid, tag} pipeline runs alongside the multiplier so that each
// product is returned to the requester that issued it. The multiplier and the
// tag pipeline advance together on a single clock enable. That enable drops
// only while the result at the output is addressed to a consumer that is not
// ready.
// Optional feature: define CH_GAIN_CAL_MUL_ARB_STAT_EN to add per-requester
// saturating 16-bit grant counters on the stat_grant_cnt port.

module ch_gain_cal_mul_mul_16s_17ns_34_4_1 (
    input  logic        clk,
    input  logic        ce,
    input  logic [15:0] din0,
    input  logic [16:0] din1,
    output logic [33:0] dout
);
    logic signed [15:0] r_a;
    logic        [16:0] r_b;
    logic signed [33:0] r_prod;
    logic signed [33:0] r_dout;
    logic signed [33:0] w_a_ext;
    logic signed [33:0] w_b_ext;

    // Sign-extend a and zero-extend b to the full product width. A 34x34 signed
    // multiply truncated to 34 bits is then exact, because |a*b| < 2^33.
    assign w_a_ext = {{18{r_a[15]}}, r_a};
    assign w_b_ext = {17'd0, r_b};

    // Operand capture, multiply, output register. These registers are not
    // reset; the tag pipeline valid bits say which contents are meaningful.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_a    <= din0;
            r_b    <= din1;
            r_prod <= w_a_ext * w_b_ext;
            r_dout <= r_prod;
        end
    end

    assign dout = r_dout;
endmodule

module ch_gain_cal_mul_arb #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [17*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     res_valid,
    input  logic [NUM_REQ-1:0]     res_ready,
    output logic [33:0]            res_data
`ifdef CH_GAIN_CAL_MUL_ARB_STAT_EN
    ,
    output logic [16*NUM_REQ-1:0]  stat_grant_cnt
`endif
);
    // Multiplier latency in clock-enabled cycles; the tag pipeline matches it.
    localparam int DEPTH = 3;

    // Arbitration state.
    logic [TAG_W-1:0]   r_rr_ptr;
    logic [TAG_W-1:0]   w_rr_ptr_next;

    // Tag pipeline: index 0 is filled from the grant; index DEPTH-1 lines up
    // with the multiplier output.
    logic [DEPTH-1:0]   r_vld;
    logic [TAG_W-1:0]   r_tag [DEPTH];

    logic               w_out_vld;
    logic [TAG_W-1:0]   w_out_tag;
    logic [NUM_REQ-1:0] w_tag_hit;
    logic               w_out_ready;
    logic               w_ce;

    // Candidate i is the requester searched at position i, counted from r_rr_ptr.
    logic [TAG_W-1:0]   w_cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand_vld;

    logic               w_grant_any;
    logic [TAG_W-1:0]   w_grant_idx;

    logic [15:0]        w_din0;
    logic [16:0]        w_din1;
    logic [33:0]        w_dout;

    assign w_out_vld = r_vld[DEPTH-1];
    assign w_out_tag = r_tag[DEPTH-1];

    // Stall only when a valid result sits at the output and its own consumer
    // is not ready. The other consumers' ready bits never matter.
    assign w_out_ready = |(w_tag_hit & res_ready);
    assign w_ce        = ~(w_out_vld & ~w_out_ready);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [TAG_W:0] w_sum;

            // Wrap r_rr_ptr + gi into 0..NUM_REQ-1. The sum is below
            // 2*NUM_REQ, so one conditional subtract is enough.
            assign w_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(gi);
            assign w_cand_idx[gi] = (w_sum >= (TAG_W+1)'(NUM_REQ))
                                  ? TAG_W'(w_sum - (TAG_W+1)'(NUM_REQ))
                                  : w_sum[TAG_W-1:0];
            assign w_cand_vld[gi] = |(req_valid & (NUM_REQ'(1) << w_cand_idx[gi]));

            // Output routing and the grant handshake for requester gi.
            assign w_tag_hit[gi] = (w_out_tag == TAG_W'(gi));
            assign res_valid[gi] = ap_rst_n & w_out_vld & w_tag_hit[gi];
            assign req_ready[gi] = w_grant_any & (w_grant_idx == TAG_W'(gi));
        end
    endgenerate

    // Pick the first valid candidate in round-robin order. No grant is made
    // while stalled or in reset.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand_vld[k]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand_idx[k];
            end
        end
        if (!w_ce || !ap_rst_n) begin
            w_grant_any = 1'b0;
            w_grant_idx = '0;
        end
    end

    // After a grant the pointer moves one past the winner; otherwise it holds.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (w_grant_any) begin
            if (w_grant_idx == TAG_W'(NUM_REQ - 1)) begin
                w_rr_ptr_next = '0;
            end else begin
                w_rr_ptr_next = w_grant_idx + TAG_W'(1);
            end
        end
    end

    // Steer the granted operands into the multiplier. Bubbles are driven as zero.
    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ready[k]) begin
                w_din0 = req_a[16*k +: 16];
                w_din1 = req_b[17*k +: 17];
            end
        end
    end

    // Round-robin pointer and tag-pipeline valids. Reset drops everything in flight.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_rr_ptr <= '0;
            r_vld    <= '0;
        end else if (w_ce) begin
            r_rr_ptr <= w_rr_ptr_next;
            r_vld    <= {r_vld[DEPTH-2:0], w_grant_any};
        end
    end

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tag
            // Shift the tag one stage forward whenever the multiplier advances.
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_tag[gi] <= '0;
                end else if (w_ce) begin
                    if (gi == 0) begin
                        r_tag[gi] <= w_grant_idx;
                    end else begin
                        r_tag[gi] <= r_tag[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    ch_gain_cal_mul_mul_16s_17ns_34_4_1 u_mul (
        .clk  (ap_clk),
        .ce   (w_ce),
        .din0 (w_din0),
        .din1 (w_din1),
        .dout (w_dout)
    );

    assign res_data = w_dout;

`ifdef CH_GAIN_CAL_MUL_ARB_STAT_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            logic [15:0] r_grant_cnt;

            // Count accepted operands for this requester, saturating at all-ones.
            always_ff @(posedge ap_clk) begin
                if (!ap_rst_n) begin
                    r_grant_cnt <= '0;
                end else if (req_valid[gi] && req_ready[gi] && (r_grant_cnt != 16'hFFFF)) begin
                    r_grant_cnt <= r_grant_cnt + 16'd1;
                end
            end

            assign stat_grant_cnt[16*gi +: 16] = r_grant_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ch_gain_cal_mul_arb.sv
// Testbench for ch_gain_cal_mul_arb (NUM_REQ=2). The reference model keeps a
// queue of in-flight products, each with the cycle in which it is due at the
// output. A stall cycle pushes back the due cycle of every in-flight product
// by one. Arbitration follows the round-robin rule. When the design is built
// with CH_GAIN_CAL_MUL_ARB_STAT_EN, the grant counters are also checked.
module tb_ch_gain_cal_mul_arb;
    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 2;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [33:0] req_b = '0;
    logic [1:0]  res_valid;
    logic [1:0]  res_ready = '0;
    logic [33:0] res_data;
`ifdef CH_GAIN_CAL_MUL_ARB_STAT_EN
    logic [31:0] stat_grant_cnt;
`endif

    always #5 ap_clk = ~ap_clk;

    ch_gain_cal_mul_arb #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef CH_GAIN_CAL_MUL_ARB_STAT_EN
        ,
        .stat_grant_cnt (stat_grant_cnt)
`endif
    );

    typedef struct {
        int          tag;
        logic [33:0] prod;
        int          due;
    } item_t;

    typedef struct {
        logic [1:0]  rv;
        logic [33:0] d;
    } rec_t;

    typedef struct {
        logic [1:0] v;
        logic [1:0] exp_rdy;
    } vec_t;

    item_t       q[$];
    rec_t        rec_q[$];
    bit          rec_en;
    int          m_rr;
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [1:0]  obs_rdy;
    logic [1:0]  obs_rv;
    logic [33:0] obs_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [33:0] ref_prod(input logic [15:0] a, input logic [16:0] b);
        longint sa;
        longint ub;
        longint p;
        sa = longint'($signed(a));
        ub = longint'(b);
        p  = sa * ub;
        return p[33:0];
    endfunction

    // One clock cycle: drive the inputs, check the outputs against the model,
    // advance the model to the state after the coming edge, then wait for the
    // next negative edge.
    task automatic step(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [16:0] b0, input logic [16:0] b1,
                        input logic [1:0] rdy, input logic rst);
        bit         head;
        bit         ce;
        int         g;
        int         idx;
        logic [1:0] erdy;
        logic [1:0] erv;
        item_t      it;

        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        res_ready = rdy;
        ap_rst_n  = ~rst;
        #1;

        head = (q.size() > 0) && (q[0].due <= cyc);
        erv  = 2'b00;
        if (!rst && head) erv = 2'b01 << q[0].tag;
        ce = 1'b1;
        if (head) ce = rdy[q[0].tag];
        g = -1;
        if (!rst && ce) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_rr + k) % NUM_REQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        erdy = (g >= 0) ? (2'b01 << g) : 2'b00;

        obs_rdy  = req_ready;
        obs_rv   = res_valid;
        obs_data = res_data;
        chk("req_ready", 64'(obs_rdy), 64'(erdy));
        chk("res_valid", 64'(obs_rv), 64'(erv));
        if (erv != 2'b00) chk("res_data", 64'(obs_data), 64'(q[0].prod));

        if (rec_en && ((obs_rv & rdy) != 2'b00)) rec_q.push_back('{rv: obs_rv, d: obs_data});

        if (rst) begin
            q.delete();
            m_rr = 0;
        end else begin
            if (!ce) begin
                foreach (q[i]) q[i].due = q[i].due + 1;
            end else if (head) begin
                void'(q.pop_front());
            end
            if (g >= 0) begin
                it.tag  = g;
                it.prod = (g == 1) ? ref_prod(a1, b1) : ref_prod(a0, b0);
                it.due  = cyc + 3;
                q.push_back(it);
                m_rr = (g + 1) % NUM_REQ;
            end
        end
        cyc++;
        @(negedge ap_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 16'd0, 16'd0, 17'd0, 17'd0, 2'b11, 1'b0);
    endtask

    vec_t            tbl[10];
    logic [33:0]     exp_single;
    logic [1:0]      rdy1;
    logic [15:0]     ra0;
    logic [15:0]     ra1;
    logic [16:0]     rb0;
    logic [16:0]     rb1;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_rr     = 0;
        rec_en   = 1'b0;

        // Grant patterns from a fresh pointer, all consumers ready.
        tbl[0] = '{v: 2'b11, exp_rdy: 2'b01};
        tbl[1] = '{v: 2'b11, exp_rdy: 2'b10};
        tbl[2] = '{v: 2'b10, exp_rdy: 2'b10};
        tbl[3] = '{v: 2'b10, exp_rdy: 2'b10};
        tbl[4] = '{v: 2'b01, exp_rdy: 2'b01};
        tbl[5] = '{v: 2'b00, exp_rdy: 2'b00};
        tbl[6] = '{v: 2'b11, exp_rdy: 2'b10};
        tbl[7] = '{v: 2'b01, exp_rdy: 2'b01};
        tbl[8] = '{v: 2'b01, exp_rdy: 2'b01};
        tbl[9] = '{v: 2'b00, exp_rdy: 2'b00};

        // Reset state: nothing is ready or valid during or after reset.
        step(2'b11, 16'd1, 16'd2, 17'd1, 17'd1, 2'b11, 1'b1);
        step(2'b11, 16'd1, 16'd2, 17'd1, 17'd1, 2'b11, 1'b1);
        idle(2);

        // Table-driven arbitration vectors.
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].v, 16'(k), 16'(k + 16), 17'd3, 17'd5, 2'b11, 1'b0);
            chk($sformatf("tbl_ready[%0d]", k), 64'(obs_rdy), 64'(tbl[k].exp_rdy));
        end
        idle(5);

        // Single op at the signed/unsigned extremes: exactly 3 cycles of latency.
        step(2'b00, 16'd0, 16'd0, 17'd0, 17'd0, 2'b11, 1'b1);
        step(2'b01, 16'h8000, 16'd0, 17'h1FFFF, 17'd0, 2'b11, 1'b0);
        chk("single_accept", 64'(obs_rdy), 64'(2'b01));
        idle(1);
        chk("single_lat1", 64'(obs_rv), 64'(2'b00));
        idle(1);
        chk("single_lat2", 64'(obs_rv), 64'(2'b00));
        idle(1);
        exp_single = -34'sd4294934528;
        chk("single_valid", 64'(obs_rv), 64'(2'b01));
        chk("single_data", 64'(obs_data), 64'(exp_single));
        idle(2);

        // Fairness: both requesters valid, grants alternate and results come back in order.
        step(2'b00, 16'd0, 16'd0, 17'd0, 17'd0, 2'b11, 1'b1);
        rec_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(2'b11, 16'(i), 16'(i), 17'd1, 17'd1, 2'b11, 1'b0);
            chk($sformatf("fair_grant[%0d]", i), 64'(obs_rdy), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
        end
        idle(5);
        rec_en = 1'b0;
        chk("fair_count", 64'(rec_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rec_q.size(); i++) begin
            chk($sformatf("fair_tag[%0d]", i), 64'(rec_q[i].rv), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("fair_data[%0d]", i), 64'(rec_q[i].d), 64'(i));
        end

        // Backpressure: stream on req1 and hold its consumer off for 5 cycles
        // from the moment the first result appears.
        for (int k = 0; k < 3; k++) step(2'b10, 16'd0, 16'(100 + k), 17'd0, 17'd2, 2'b11, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(2'b10, 16'd0, 16'(103 + k), 17'd0, 17'd2, 2'b01, 1'b0);
            chk($sformatf("bp_ready[%0d]", k), 64'(obs_rdy), 64'(2'b00));
            chk($sformatf("bp_valid[%0d]", k), 64'(obs_rv), 64'(2'b10));
            chk($sformatf("bp_data[%0d]", k), 64'(obs_data), 64'd200);
        end
        for (int k = 0; k < 4; k++) step(2'b10, 16'd0, 16'(103 + k), 17'd0, 17'd2, 2'b11, 1'b0);
        idle(6);

        // Mixed consumers: consumer 0 always ready, consumer 1 toggling.
        for (int k = 0; k < 40; k++) begin
            rdy1 = {1'(k % 2), 1'b1};
            step(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 17'($urandom), 17'($urandom), rdy1, 1'b0);
        end
        idle(8);

        // Reset with three ops in flight: they never come out, and req0 wins next.
        for (int k = 0; k < 3; k++) step(2'b01, 16'(7 + k), 16'd0, 17'd9, 17'd0, 2'b11, 1'b0);
        step(2'b00, 16'd0, 16'd0, 17'd0, 17'd0, 2'b11, 1'b1);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk($sformatf("rst_flush[%0d]", k), 64'(obs_rv), 64'(2'b00));
        end
        step(2'b11, 16'd5, 16'd6, 17'd1, 17'd1, 2'b11, 1'b0);
        chk("rst_first_grant", 64'(obs_rdy), 64'(2'b01));
        idle(5);

        // Random traffic with random backpressure and occasional resets.
        for (int k = 0; k < 400; k++) begin
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            rb0 = 17'($urandom);
            rb1 = 17'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ra0 = 16'h8000;
                rb0 = 17'h1FFFF;
            end
            step(2'($urandom_range(0, 3)), ra0, ra1, rb0, rb1,
                 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end
        idle(12);
        chk("drained", 64'(q.size()), 64'd0);

`ifdef CH_GAIN_CAL_MUL_ARB_STAT_EN
        // Grant counters clear on reset and saturate.
        step(2'b00, 16'd0, 16'd0, 17'd0, 17'd0, 2'b11, 1'b1);
        idle(1);
        chk("stat_reset", 64'(stat_grant_cnt), 64'd0);
        for (int k = 0; k < 70000; k++) step(2'b01, 16'(k), 16'd0, 17'd1, 17'd0, 2'b11, 1'b0);
        idle(5);
        chk("stat_cnt0", 64'(stat_grant_cnt[15:0]), 64'h0000_FFFF);
        chk("stat_cnt1", 64'(stat_grant_cnt[31:16]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
